// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, FSM state type and the round-robin search helper
// for the 8:1 mux arbiter.
package rr_mux_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set bit of req scanning upward from last+1, wrapping 7 -> 0.
    // The last grantee is checked last, so it has the lowest priority.
    // The scan runs from the farthest candidate back to the nearest, so the
    // nearest requester overwrites the result. The caller guarantees req != 0.
    function automatic logic [SEL_W-1:0] rr_next(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] idx;
        rr_next = last;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = last + SEL_W'(k);
            if (req[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux8.sv
// 8:1 single-bit data mux. The arbiter is the only driver of its select.
module mux8
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] in,
    input  logic [SEL_W-1:0] sel,
    output logic             out
);

    assign out = in[sel];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter / sequencer in front of an 8:1 bit mux. It grants one
// requester at a time for at most MAX_BEATS accepted beats. Each grant is
// followed by a single IDLE bubble.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] in,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             out_valid,
    output logic             out,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_last;
    logic [N_REQ-1:0] r_grant;
    logic [7:0]       r_cnt;

    logic [SEL_W-1:0] w_next;
    logic             w_in_grant;
    logic             w_beat;
    logic [7:0]       w_cnt_nxt;
    logic             w_release;

    assign w_next     = rr_next(req, r_last);
    assign w_in_grant = (r_state == GRANT);
    // out_valid depends only on req and registered state, never on out_ready.
    assign out_valid  = w_in_grant & req[r_sel];
    assign w_beat     = out_valid & out_ready;
    assign w_cnt_nxt  = r_cnt + 8'd1;
    // A dropped request ends the grant even without a beat. Otherwise the
    // grant ends on the handshake that brings the beat count to MAX_BEATS.
    assign w_release  = ~req[r_sel] | (w_beat & (w_cnt_nxt == MAX_B));

    assign sel   = r_sel;
    assign grant = r_grant;
    assign busy  = w_in_grant;

    // The data path shows in[sel] at all times. It is only meaningful while out_valid is high.
    mux8 u_mux8 (
        .in  (in),
        .sel (r_sel),
        .out (out)
    );

    // FSM: arbitrate in IDLE, count beats and decide release in GRANT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_grant <= '0;
            r_last  <= SEL_W'(N_REQ - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_sel   <= w_next;
                        r_grant <= N_REQ'(1) << w_next;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_beat) r_cnt <= w_cnt_nxt;
                    if (w_release) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_last  <= r_sel;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter. Instance A uses MAX_BEATS=4 and instance B uses MAX_BEATS=1.
// The stimulus pushes the expected beats. A monitor per instance pops one
// entry on every accepted beat.
module tb_rr_mux_arbiter;

    typedef struct {
        logic [2:0] idx;
        logic       b;
    } beat_t;

    logic       clk;
    logic       rst;
    logic [7:0] req_a, in_a, grant_a, req_b, in_b, grant_b;
    logic [2:0] sel_a, sel_b;
    logic       ov_a, out_a, rdy_a, busy_a;
    logic       ov_b, out_b, rdy_b, busy_b;

    int n_cmp = 0;
    int n_err = 0;
    beat_t qa[$];
    beat_t qb[$];

    rr_mux_arbiter #(.MAX_BEATS(4)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .in(in_a), .sel(sel_a),
        .grant(grant_a), .out_valid(ov_a), .out(out_a), .out_ready(rdy_a),
        .busy(busy_a)
    );

    rr_mux_arbiter #(.MAX_BEATS(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .in(in_b), .sel(sel_b),
        .grant(grant_b), .out_valid(ov_b), .out(out_b), .out_ready(rdy_b),
        .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int idx, input int n);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.idx = 3'(idx);
            e.b   = in_a[idx];
            qa.push_back(e);
        end
    endtask

    task automatic push_b(input int idx);
        beat_t e;
        e.idx = 3'(idx);
        e.b   = in_b[idx];
        qb.push_back(e);
    endtask

    // Grant to a at P1, release at P5, grant to b at P6, release at P10; then drop req.
    task automatic two_grants(input logic [7:0] r, input int a, input int b);
        req_a = r;
        push_a(a, 4);
        push_a(b, 4);
        tick();
        chk("tg_grant_a", grant_a, 32'(8'd1 << a));
        chk("tg_sel_a", sel_a, 32'(a));
        chk("tg_busy_a", busy_a, 1);
        repeat (4) tick();
        chk("tg_bubble", grant_a, 0);
        chk("tg_bubble_busy", busy_a, 0);
        tick();
        chk("tg_grant_b", grant_a, 32'(8'd1 << b));
        chk("tg_sel_b", sel_a, 32'(b));
        repeat (4) tick();
        chk("tg_release_b", grant_a, 0);
        req_a = 8'h00;
    endtask

    // Accepted-beat monitors: each handshake must match the oldest expected beat.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && ov_a && rdy_a) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL beat_a: unexpected beat sel=%0d out=%0b at %0t", sel_a, out_a, $time);
            end else begin
                e = qa.pop_front();
                if (sel_a !== e.idx || grant_a !== (8'd1 << e.idx) || out_a !== e.b) begin
                    n_err++;
                    $display("FAIL beat_a: got sel=%0d grant=%0h out=%0b expected sel=%0d out=%0b at %0t",
                             sel_a, grant_a, out_a, e.idx, e.b, $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst && ov_b && rdy_b) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL beat_b: unexpected beat sel=%0d out=%0b at %0t", sel_b, out_b, $time);
            end else begin
                e = qb.pop_front();
                if (sel_b !== e.idx || grant_b !== (8'd1 << e.idx) || out_b !== e.b) begin
                    n_err++;
                    $display("FAIL beat_b: got sel=%0d grant=%0h out=%0b expected sel=%0d out=%0b at %0t",
                             sel_b, grant_b, out_b, e.idx, e.b, $time);
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        req_a = 8'h00; in_a = 8'h69; rdy_a = 1'b1;
        req_b = 8'h00; in_b = 8'h10; rdy_b = 1'b1;
        repeat (2) tick();
        chk("rst_grant", grant_a, 0);
        chk("rst_sel", sel_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", ov_a, 0);
        rst = 1'b0;
        tick();

        // Reset asserted while requester 2 is streaming.
        req_a = 8'h04;
        push_a(2, 2);
        tick();
        chk("pre_rst_grant", grant_a, 32'h04);
        chk("pre_rst_sel", sel_a, 2);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("midrst_grant", grant_a, 0);
        chk("midrst_valid", ov_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_sel", sel_a, 0);
        req_a = 8'h00;
        tick();
        rst = 1'b0;

        // After reset requester 0 has first priority, then 2.
        two_grants(8'h05, 0, 2);
        // A single persistent requester gets a one-cycle bubble between its grants.
        two_grants(8'h08, 3, 3);

        // Round robin across all eight requesters, starting from reset priority.
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        req_a = 8'hFF;
        for (int i = 0; i < 8; i++) push_a(i, 4);
        push_a(0, 4);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("rr_grant", grant_a, 32'(8'd1 << (i % 8)));
            repeat (3) tick();
            tick();
            chk("rr_gap", grant_a, 0);
        end
        req_a = 8'h00;

        // Backpressure: 10-cycle stall, grant held, then exactly 4 beats.
        req_a = 8'h20;
        rdy_a = 1'b0;
        push_a(5, 4);
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("bp_hold", grant_a, 32'h20);
        end
        rdy_a = 1'b1;
        repeat (3) tick();
        chk("bp_last_beat", grant_a, 32'h20);
        tick();
        chk("bp_release", grant_a, 0);
        req_a = 8'h00;

        // Early drop: 6 drops after 2 beats. Requester 1 arrived mid-grant and is next.
        req_a = 8'h40;
        push_a(6, 2);
        push_a(1, 4);
        tick();
        chk("ed_grant6", grant_a, 32'h40);
        req_a = 8'h42;
        tick();
        chk("ed_no_preempt", grant_a, 32'h40);
        tick();
        req_a = 8'h02;
        tick();
        chk("ed_release", grant_a, 0);
        tick();
        chk("ed_grant1", grant_a, 32'h02);
        chk("ed_sel1", sel_a, 1);
        repeat (3) tick();
        tick();
        chk("ed_release1", grant_a, 0);
        req_a = 8'h00;

        // Drop with out_ready low: release, no beat.
        req_a = 8'h08;
        push_a(3, 1);
        tick();
        chk("dl_grant", grant_a, 32'h08);
        tick();
        rdy_a = 1'b0;
        req_a = 8'h00;
        tick();
        chk("dl_release", grant_a, 0);
        chk("dl_sel_hold", sel_a, 3);
        rdy_a = 1'b1;

        // MAX_BEATS = 1 alternates 4, 5, 4, 5 with one beat each.
        req_b = 8'h30;
        push_b(4); push_b(5); push_b(4); push_b(5);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mb1_grant", grant_b, (i % 2 == 0) ? 32'h10 : 32'h20);
            tick();
            chk("mb1_gap", grant_b, 0);
        end
        req_b = 8'h00;

        repeat (3) tick();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
